// File: rtl/trace_sequencer.sv
// ---------------------------------------------------------------------------
// trace_sequencer
//
// Frame-level controller for the column tracer. Once per frame, during
// VBLANK, it opens a tracing window: it snapshots the camera vectors
// (ARM), runs the tracer (RUN) until completion, deadline or gating, and
// then reports status.
//
// Optional feature macro: TRACE_CYCLE_COUNT_EN
//   defined   : builds the 16-bit RUN cycle counter and cycle_count register
//   undefined : no counter logic, cycle_count tied to 0
//
// Ports:
//   clk, reset       single clock, asynchronous active-high reset
//   go_en            global run gate
//   h, v             current beam position
//   cam_valid/ready  camera handshake; cam_data is the packed camera word
//                    {playerX, playerY, facingX, facingY, vplaneX, vplaneY}
//   cam_active       camera snapshot driven to the tracer (same packing)
//   tracer_enable    tracer enable, high only in RUN
//   tracer_store     tracer store strobe
//   tracer_column    tracer column index
//   frame_count      frames armed (wraps at 2047)
//   busy             high in ARM and RUN
//   done             one-cycle pulse on normal completion
//   overrun          sticky deadline-miss flag
//   cycle_count      RUN cycles of the last finished or aborted trace
// ---------------------------------------------------------------------------
module trace_sequencer #(
    parameter int FW       = 16,
    parameter int V_START  = 480,
    parameter int V_END    = 524,
    parameter int H_MAX    = 799,
    parameter int LAST_COL = 639
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go_en,
    input  logic [9:0]      h,
    input  logic [9:0]      v,
    input  logic            cam_valid,
    output logic            cam_ready,
    input  logic [6*FW-1:0] cam_data,
    output logic [6*FW-1:0] cam_active,
    output logic            tracer_enable,
    input  logic            tracer_store,
    input  logic [9:0]      tracer_column,
    output logic [10:0]     frame_count,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    output logic [15:0]     cycle_count
);

    localparam logic [9:0] V_START_L  = 10'(V_START);
    localparam logic [9:0] V_END_L    = 10'(V_END);
    localparam logic [9:0] H_MAX_L    = 10'(H_MAX);
    localparam logic [9:0] LAST_COL_L = 10'(LAST_COL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [6*FW-1:0] pending;
    logic            pending_dirty;

    logic cam_xfer;
    logic arm_hit;
    logic run_complete;
    logic deadline;

    assign cam_xfer     = cam_valid && cam_ready;
    assign arm_hit      = go_en && (v == V_START_L) && (h == 10'd0);
    assign run_complete = tracer_store && (tracer_column == LAST_COL_L);
    assign deadline     = (v == V_END_L) && (h == H_MAX_L);

    // cam_ready and busy are registered alongside the state so that every
    // output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            pending       <= '0;
            pending_dirty <= 1'b0;
            cam_active    <= '0;
            cam_ready     <= 1'b1;
            tracer_enable <= 1'b0;
            frame_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            done <= 1'b0;

            // cam_ready is low in ARM, so a transfer never collides with
            // the snapshot clearing pending_dirty below.
            if (cam_xfer) begin
                pending       <= cam_data;
                pending_dirty <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (arm_hit) begin
                        state     <= S_ARM;
                        busy      <= 1'b1;
                        cam_ready <= 1'b0;
                    end
                end

                S_ARM: begin
                    if (pending_dirty) begin
                        cam_active    <= pending;
                        pending_dirty <= 1'b0;
                    end
                    frame_count   <= frame_count + 11'd1;
                    state         <= S_RUN;
                    tracer_enable <= 1'b1;
                    cam_ready     <= 1'b1;
                end

                S_RUN: begin
                    if (run_complete) begin
                        state         <= S_DONE;
                        tracer_enable <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (deadline) begin
                        state         <= S_IDLE;
                        tracer_enable <= 1'b0;
                        busy          <= 1'b0;
                        overrun       <= 1'b1;
                    end else if (!go_en) begin
                        state         <= S_IDLE;
                        tracer_enable <= 1'b0;
                        busy          <= 1'b0;
                    end
                end

                S_DONE: begin
                    // Hold until the arming line has passed so the same
                    // line cannot trigger a second window.
                    if (v != V_START_L) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    tracer_enable <= 1'b0;
                    busy          <= 1'b0;
                    cam_ready     <= 1'b1;
                end
            endcase
        end
    end

`ifdef TRACE_CYCLE_COUNT_EN
    logic [15:0] run_cycles;
    logic [15:0] run_cycles_next;
    logic        run_exit;

    assign run_cycles_next = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    assign run_exit        = (state == S_RUN) && (run_complete || deadline || !go_en);

    // The reported count includes the exit cycle itself, so a trace that
    // holds tracer_enable for N cycles reports N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cycles  <= '0;
            cycle_count <= '0;
        end else begin
            if (state == S_ARM) begin
                run_cycles <= '0;
            end else if (state == S_RUN) begin
                run_cycles <= run_cycles_next;
            end
            if (run_exit) begin
                cycle_count <= run_cycles_next;
            end
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trace_sequencer
//
// Frame scenarios are listed in a table and replayed by run_row. A small
// camera model predicts the snapshot each frame will use; the expected
// per-frame results are queued when the frame is armed and popped when the
// trace ends. Hand-written sequences cover reset, the no-rearm hold in DONE
// and asynchronous reset mid-RUN.
// ---------------------------------------------------------------------------
module tb_trace_sequencer;

    localparam int FW = 16;
    localparam int W  = 6 * FW;

    logic          clk = 1'b0;
    logic          reset;
    logic          go_en;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          cam_valid;
    logic          cam_ready;
    logic [W-1:0]  cam_data;
    logic [W-1:0]  cam_active;
    logic          tracer_enable;
    logic          tracer_store;
    logic [9:0]    tracer_column;
    logic [10:0]   frame_count;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [15:0]   cycle_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    trace_sequencer #(
        .FW       (FW),
        .V_START  (480),
        .V_END    (524),
        .H_MAX    (799),
        .LAST_COL (639)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go_en         (go_en),
        .h             (h),
        .v             (v),
        .cam_valid     (cam_valid),
        .cam_ready     (cam_ready),
        .cam_data      (cam_data),
        .cam_active    (cam_active),
        .tracer_enable (tracer_enable),
        .tracer_store  (tracer_store),
        .tracer_column (tracer_column),
        .frame_count   (frame_count),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           pre;      // write camera data in IDLE before arming
        logic [W-1:0] pre_d;
        bit           arm;      // hold cam_valid starting in the ARM cycle
        logic [W-1:0] arm_d;
        bit           mid;      // write camera data in RUN cycle 3
        logic [W-1:0] mid_d;
        int           store_at; // RUN cycle of completion strobe (0 = none)
        int           dl;       // RUN cycle at which the deadline is hit (0 = none)
        int           drop;     // RUN cycle at which go_en drops (0 = none)
        bit           e_done;
        bit           e_ov;
        int           e_cyc;
    } row_t;

    typedef struct {
        logic [W-1:0] cam;
        bit           done;
        bit           ov;
        logic [15:0]  cyc;
        logic [10:0]  fc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_pend;
    logic [W-1:0] m_cam;
    bit           m_dirty;
    logic [10:0]  m_fc;
    row_t         rows[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cc_exp(input int c);
`ifdef TRACE_CYCLE_COUNT_EN
        return 16'(c);
`else
        return 16'(c - c);
`endif
    endfunction

    // One clock: DUT samples at the edge, outputs are read 1 time unit later,
    // then the bench beam advances to the position sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (h == 10'd799) begin
            h = 10'd0;
            v = (v == 10'd524) ? 10'd0 : v + 10'd1;
        end else begin
            h = h + 10'd1;
        end
    endtask

    task automatic run_row(input row_t r, input int idx);
        exp_t e;
        int   n;
        int   bad;
        int   guard;
        go_en = 1'b1;
        v = 10'd100;
        h = 10'd0;
        tick();
        tick();
        if (r.pre) begin
            cam_valid = 1'b1;
            cam_data  = r.pre_d;
            check($sformatf("r%0d_ready_idle", idx), 128'(cam_ready), 128'(1));
            tick();
            cam_valid = 1'b0;
            m_pend  = r.pre_d;
            m_dirty = 1'b1;
        end
        if (m_dirty) m_cam = m_pend;
        m_dirty = 1'b0;
        m_fc    = m_fc + 11'd1;
        e.cam  = m_cam;
        e.done = r.e_done;
        e.ov   = r.e_ov;
        e.cyc  = cc_exp(r.e_cyc);
        e.fc   = m_fc;
        sb.push_back(e);

        v = 10'd480;
        h = 10'd0;
        tick();
        check($sformatf("r%0d_arm_busy", idx), 128'(busy), 128'(1));
        check($sformatf("r%0d_arm_enable", idx), 128'(tracer_enable), 128'(0));
        check($sformatf("r%0d_arm_ready", idx), 128'(cam_ready), 128'(0));
        if (r.arm) begin
            cam_valid = 1'b1;
            cam_data  = r.arm_d;
            m_pend  = r.arm_d;
            m_dirty = 1'b1;
        end
        tick();
        check($sformatf("r%0d_run_ready", idx), 128'(cam_ready), 128'(1));

        n = 0;
        bad = 0;
        guard = 0;
        while (tracer_enable === 1'b1 && guard < 20000) begin
            n++;
            guard++;
            if (cam_active !== sb[0].cam || busy !== 1'b1) bad++;
            tracer_store  = 1'b0;
            tracer_column = 10'd0;
            if (n == 1 && r.dl > 0) begin
                v = 10'd524;
                h = 10'(800 - r.dl);
            end
            if (r.store_at > 2 && n == r.store_at - 1) begin
                tracer_store  = 1'b1;
                tracer_column = 10'd638;
            end
            if (n == r.store_at) begin
                tracer_store  = 1'b1;
                tracer_column = 10'd639;
            end
            if (r.arm && n == 2) cam_valid = 1'b0;
            if (r.mid && n == 3) begin
                cam_valid = 1'b1;
                cam_data  = r.mid_d;
                m_pend  = r.mid_d;
                m_dirty = 1'b1;
            end
            if (r.mid && n == 4) cam_valid = 1'b0;
            if (n == r.drop) go_en = 1'b0;
            tick();
        end
        tracer_store  = 1'b0;
        tracer_column = 10'd0;
        cam_valid     = 1'b0;

        e = sb.pop_front();
        check($sformatf("r%0d_bounded", idx), 128'(guard < 20000), 128'(1));
        check($sformatf("r%0d_run_stable", idx), 128'(bad), 128'(0));
        check($sformatf("r%0d_enable_cycles", idx), 128'(n), 128'(r.e_cyc));
        check($sformatf("r%0d_done", idx), 128'(done), 128'(e.done));
        check($sformatf("r%0d_overrun", idx), 128'(overrun), 128'(e.ov));
        check($sformatf("r%0d_cycle_count", idx), 128'(cycle_count), 128'(e.cyc));
        check($sformatf("r%0d_frame_count", idx), 128'(frame_count), 128'(e.fc));
        check($sformatf("r%0d_cam_active", idx), 128'(cam_active), 128'(e.cam));
        check($sformatf("r%0d_busy_after", idx), 128'(busy), 128'(0));
        tick();
        check($sformatf("r%0d_done_end", idx), 128'(done), 128'(0));
        check($sformatf("r%0d_enable_end", idx), 128'(tracer_enable), 128'(0));
        go_en = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ca, cb, cc, cd, ce, cf;
        ca = 96'h1111_0001_0002_0003_0004_0005;
        cb = 96'h2222_00A1_00A2_00A3_00A4_00A5;
        cc = 96'h3333_0B01_0B02_0B03_0B04_0B05;
        cd = 96'h4444_C001_C002_C003_C004_C005;
        ce = 96'h5555_DEAD_BEEF_0123_4567_89AB;
        cf = 96'h6666_FFFF_0000_FFFF_0000_FFFF;

        //          pre arm mid            store dl  drop done ov  cyc
        rows[0] = '{1, ca, 0, '0, 0, '0,   10000, 0,  0,   1,   0,  10000};
        rows[1] = '{1, cb, 0, '0, 1, cc,   20,    20, 0,   1,   0,  20};
        rows[2] = '{0, '0, 1, cd, 0, '0,   0,     0,  50,  0,   0,  50};
        rows[3] = '{0, '0, 0, '0, 0, '0,   0,     30, 0,   0,   1,  30};
        rows[4] = '{1, ce, 0, '0, 0, '0,   5,     0,  0,   1,   1,  5};
        rows[5] = '{0, '0, 0, '0, 0, '0,   3,     0,  0,   1,   0,  3};

        reset = 1'b1;
        go_en = 1'b0;
        h = 10'd0;
        v = 10'd0;
        cam_valid = 1'b0;
        cam_data = '0;
        tracer_store = 1'b0;
        tracer_column = 10'd0;
        m_pend = '0;
        m_cam = '0;
        m_dirty = 1'b0;
        m_fc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 128'(tracer_enable), 128'(0));
        check("rst_ready", 128'(cam_ready), 128'(1));
        check("rst_cam_active", 128'(cam_active), 128'(0));
        check("rst_frame_count", 128'(frame_count), 128'(0));
        check("rst_flags", 128'({busy, done, overrun}), 128'(0));
        check("rst_cycle_count", 128'(cycle_count), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_row(rows[i], i);
        end

        // Still on the arming line after a short trace: DONE must not re-arm.
        v = 10'd480;
        h = 10'd0;
        tick();
        tick();
        tick();
        check("done_hold_busy", 128'(busy), 128'(0));
        check("done_hold_enable", 128'(tracer_enable), 128'(0));
        check("done_hold_frame", 128'(frame_count), 128'(m_fc));

        // Asynchronous reset mid-RUN, with fresh pending data that must be lost.
        go_en = 1'b1;
        v = 10'd100;
        h = 10'd0;
        tick();
        tick();
        v = 10'd480;
        h = 10'd0;
        tick();
        tick();
        check("rstrun_enable_before", 128'(tracer_enable), 128'(1));
        cam_valid = 1'b1;
        cam_data  = cf;
        tick();
        cam_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rstrun_enable", 128'(tracer_enable), 128'(0));
        check("rstrun_busy", 128'(busy), 128'(0));
        check("rstrun_ready", 128'(cam_ready), 128'(1));
        check("rstrun_cam_active", 128'(cam_active), 128'(0));
        check("rstrun_frame_count", 128'(frame_count), 128'(0));
        check("rstrun_overrun", 128'(overrun), 128'(0));
        check("rstrun_cycle_count", 128'(cycle_count), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        m_pend = '0;
        m_cam = '0;
        m_dirty = 1'b0;
        m_fc = '0;
        run_row(rows[5], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_sequencer.md
# trace_sequencer

Frame-level controller for the column tracer. It watches the VGA beam position and opens one tracing window per frame during VBLANK. At the start of each window it snapshots the camera vectors so they stay stable for the whole trace, then sequences the tracer's enable. It also detects completion or deadline overrun and reports per-frame status and trace cycle counts.

## Interface

Parameters:
- `FW`, 16: fixed-point word width; must equal the `F` width in fixed_point_params.v.
- `V_START`, 480: line on which tracing may begin.
- `V_END`, 524: last line of the tracing window.
- `H_MAX`, 799: last pixel clock of a line.
- `LAST_COL`, 639: tracer column index that marks trace completion.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `go_en` in 1: global run gate.
- `h` in 10: current horizontal beam position.
- `v` in 10: current vertical beam position.
- `cam_valid` in 1: host presents new camera data.
- `cam_ready` out 1: sequencer can accept camera data this cycle.
- `cam_data` in 6*FW: {playerX, playerY, facingX, facingY, vplaneX, vplaneY}, with playerX in the MSBs.
- `cam_active` out 6*FW: snapshot driven to the tracer; same packing as `cam_data`.
- `tracer_enable` out 1: drives the tracer's enable input.
- `tracer_store` in 1: tracer store strobe.
- `tracer_column` in 10: tracer column output.
- `frame_count` out 11: frames armed; drives the tracer's debug_frame.
- `busy` out 1: high while in ARM or RUN.
- `done` out 1: one-cycle pulse on normal completion.
- `overrun` out 1: sticky flag, set when a deadline is missed.
- `cycle_count` out 16: RUN cycles used by the last finished or aborted trace.

## Operation

- Reset values: state IDLE, `tracer_enable`=0, `cam_active`=0, pending=0, pending_dirty=0, `frame_count`=0, `done`=0, `overrun`=0, `cycle_count`=0. `cam_ready`=1 during reset release.
- Camera handshake: a transfer occurs when `cam_valid` and `cam_ready` are both high. On transfer, pending<=`cam_data` and pending_dirty<=1. `cam_ready`=1 in every state except ARM. A later transfer overwrites earlier pending data (last write wins).
- IDLE: when `go_en` is high, v==`V_START` and h==0, go to ARM.
- ARM (1 cycle):
  - If pending_dirty, `cam_active`<=pending and pending_dirty<=0; otherwise `cam_active` holds.
  - `frame_count`<=`frame_count`+1, wrapping 2047->0.
  - The cycle counter is cleared.
  - Go to RUN.
- RUN: `tracer_enable`=1 and the cycle counter increments each cycle, saturating at 0xFFFF. Exit conditions, evaluated in this priority order:
  - (a) `tracer_store` high and `tracer_column`==`LAST_COL`: go to DONE, `done` pulses.
  - (b) v==`V_END` and h==`H_MAX`: go to IDLE, `overrun`<=1.
  - (c) `go_en` low: go to IDLE with no `done` and no `overrun`.
- On every exit from RUN, `cycle_count`<=counter value.
- DONE: `tracer_enable`=0. Stay until v!=`V_START`, then go to IDLE. This prevents re-arming within the same line.
- `tracer_enable` is low in every state except RUN. The tracer therefore sees at least one low cycle (ARM) before each trace, which resets its internal state.

## Timing

- `tracer_enable` and all status outputs are registered.
- Cycle c: IDLE samples v==`V_START`, h==0. Cycle c+1: ARM, `cam_active` updates at the end of this cycle. Cycle c+2: `tracer_enable`=1.
- If completion is sampled in cycle k, then in cycle k+1 `tracer_enable`=0 and `done`=1 for exactly one cycle.
- A `cam_valid` offered during ARM is stalled (`cam_ready`=0). It completes the next cycle and applies to the following frame.
- Completion and deadline in the same cycle: completion wins; `overrun` is not set.
- Asynchronous reset mid-RUN: `tracer_enable` drops immediately, pending data is lost, and all outputs return to their reset values.
- `cam_active` never changes while in RUN.

## Configuration

- `TRACE_CYCLE_COUNT_EN`:
  - Defined: the 16-bit RUN cycle counter and the `cycle_count` register are built as described above.
  - Undefined: no counter logic is built and `cycle_count` is tied to 0. All other behaviour is identical.

## Test plan

- Normal frame: `go_en`=1, tracer model asserts `tracer_store` with column 639 after 10000 RUN cycles -> `tracer_enable` high from 2 cycles after (v=480,h=0) for exactly 10000 cycles, one `done` pulse, `frame_count`=1, `cycle_count`=10000, `overrun`=0.
- Overrun: tracer never completes -> at (v=524,h=799) `tracer_enable` falls and `overrun`=1. `overrun` stays 1 through the next good frame, and `frame_count` increments again at the next v=480.
- Camera coherency: write camera data A before v=480, then B during RUN -> `cam_active`=A for the entire RUN, and B appears in the next frame's ARM cycle. A `cam_valid` held during ARM sees `cam_ready`=0 for one cycle, then is accepted.
- Simultaneous events: completion (store, column 639) exactly at (v=524,h=799) -> `done` pulses and `overrun` stays 0.
- Gating: drop `go_en` mid-RUN -> `tracer_enable` low next cycle, no `done`, `cycle_count` holds the partial count. Assert `reset` asynchronously mid-RUN -> `tracer_enable` low without waiting for a clock edge, and all outputs return to reset values.
- Macro off: build without `TRACE_CYCLE_COUNT_EN` and rerun the normal frame -> `cycle_count`=0, all other responses identical.
